pla_exhaustive_sweeper: RTL

- Sequential harness stage wrapped around one single-output PLA benchmark cone (9 inputs x0..x8, output y0).
- Upstream role: drives every input minterm 0..2^N_IN-1 onto the cone inputs, one per clock.
- Downstream role: consumes the cone output, compacts it into a serial signature, and counts on-set minterms.
- Used for equivalence checks of original vs optimized netlists against a golden signature.

---
 rtl/pla_sweep_pkg.sv | 18 +
 rtl/pla_exhaustive_sweeper_sisr_reg.sv | 32 +++
 rtl/pla_exhaustive_sweeper.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/pla_sweep_pkg.sv
// Shared types and constants for the PLA exhaustive sweeper.
// The sweeper's optional truth-table store is built only when PLA_TRUTH_STORE_EN is defined.
package pla_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;

  function automatic int sweep_len(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/pla_exhaustive_sweeper_sisr_reg.sv
// Serial-input signature register with Galois feedback.
// The seed is reloaded whenever load is asserted; load takes priority over en.
module sisr_reg
  import pla_sweep_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic             din,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  assign fb = sig[SIG_W-1] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig <= SEED;
    end else if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/pla_exhaustive_sweeper.sv
// Drives every minterm onto a PLA cone, compacts its output into a signature and counts on-set minterms.
// Optional macro PLA_TRUTH_STORE_EN adds a readable copy of the captured truth table.
//
// state | meaning
// IDLE  | waiting for start_i; partial results of an aborted sweep are held
// RUN   | one minterm driven and sampled per clock
// DONE  | full sweep captured; signature compared against golden_i
module pla_exhaustive_sweeper
  import pla_sweep_pkg::*;
#(
  parameter int               N_IN  = 9,
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = DEF_POLY,
  parameter logic [SIG_W-1:0] SEED  = DEF_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  output logic [N_IN-1:0]  vec_o,
  input  logic             y_i,
  input  logic [SIG_W-1:0] golden_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [SIG_W-1:0] signature_o,
  output logic [N_IN:0]    ones_o,
  input  logic [N_IN-1:0]  tt_addr_i,
  output logic             tt_bit_o
);

  localparam int              SWEEP_LEN = sweep_len(N_IN);
  localparam logic [N_IN-1:0] CNT_LAST  = N_IN'(SWEEP_LEN - 1);

  sweep_state_e    state, state_nxt;
  logic [N_IN-1:0] cnt;
  logic [N_IN:0]   ones;
  logic            sweep_load;
  logic            run_step;
  logic            cnt_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Abort outranks the final-vector transition, so it is tested first in RUN.
  always_comb begin
    state_nxt  = state;
    sweep_load = 1'b0;
    run_step   = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_nxt  = RUN;
          sweep_load = 1'b1;
          cnt_clr    = 1'b1;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_nxt = IDLE;
          cnt_clr   = 1'b1;
        end else begin
          run_step = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = DONE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_clr   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (run_step) begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones <= '0;
    end else if (sweep_load) begin
      ones <= '0;
    end else if (run_step) begin
      ones <= ones + {{N_IN{1'b0}}, y_i};
    end
  end

  sisr_reg #(
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_sisr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sweep_load),
    .en    (run_step),
    .din   (y_i),
    .sig   (signature_o)
  );

  assign vec_o  = cnt;
  assign ones_o = ones;
  assign busy_o = (state == RUN);
  assign done_o = (state == DONE);
  assign pass_o = done_o & (signature_o == golden_i);

`ifdef PLA_TRUTH_STORE_EN
  // Storage is deliberately not reset; only the read register is.
  logic tt_mem [0:SWEEP_LEN-1];

  always_ff @(posedge clk) begin
    if (run_step) begin
      tt_mem[cnt] <= y_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tt_bit_o <= 1'b0;
    end else begin
      tt_bit_o <= tt_mem[tt_addr_i];
    end
  end
`else
  logic unused_tt_addr;

  assign unused_tt_addr = ^tt_addr_i;
  assign tt_bit_o       = 1'b0;
`endif

endmodule
